// File: rtl/sync_fifo_ctrl_if.sv
// Handshake and status bundle for the single-clock FIFO.
// The master side drives write/read requests, the slave side is the FIFO itself.
interface sync_fifo_ctrl_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 4
);
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             rinc;
  logic             clr_err;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;
  logic             walmost_full;
  logic             ralmost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wdata, winc, rinc, clr_err,
    input  rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  wdata, winc, rinc, clr_err,
    output rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a standard or first-word-fall-through read port.
module sync_fifo_ctrl #(
  parameter int DSIZE     = 32,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_ctrl_if.slave  fifo_if
);

  localparam int DEPTH = 2 ** ASIZE;
  localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_CNT   = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AE_CNT   = (ASIZE+1)'(AEMPTY_TH);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [ASIZE-1:0] wptr_q, wptr_d;
  logic [ASIZE-1:0] rptr_q, rptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic wfull, rempty, wr_ok, rd_ok;

  // Flags decode the registered count only, so pointer wrap never affects them.
  assign wfull  = (count_q == FULL_CNT);
  assign rempty = (count_q == '0);
  assign rd_ok  = fifo_if.rinc & ~rempty;
  assign wr_ok  = fifo_if.winc & (~wfull | rd_ok);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (fifo_if.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (fifo_if.winc & ~wr_ok) overflow_d  = 1'b1;
      if (fifo_if.rinc & ~rd_ok) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= fifo_if.wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign fifo_if.rdata = rempty ? '0 : mem_q[rptr_q];
    end else begin : g_std
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        rdata_q <= '0;
        else if (rd_ok) rdata_q <= mem_q[rptr_q];
      end
      assign fifo_if.rdata = rdata_q;
    end
  endgenerate

  assign fifo_if.wfull         = wfull;
  assign fifo_if.rempty        = rempty;
  assign fifo_if.walmost_full  = (count_q >= AF_CNT);
  assign fifo_if.ralmost_empty = (count_q <= AE_CNT);
  assign fifo_if.count         = count_q;
  assign fifo_if.overflow      = overflow_q;
  assign fifo_if.underflow     = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench: a standard-mode FIFO checked against a queue model, plus a
// small directed run on a first-word-fall-through instance.
module tb_sync_fifo_ctrl;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DSIZE(32), .ASIZE(4)) bus0 ();
  sync_fifo_ctrl_if #(.DSIZE(32), .ASIZE(4)) bus1 ();

  sync_fifo_ctrl #(.DSIZE(32), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0))
    dut0 (.clk(clk), .rst(rst0), .fifo_if(bus0));
  sync_fifo_ctrl #(.DSIZE(32), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1))
    dut1 (.clk(clk), .rst(rst1), .fifo_if(bus1));

  logic [31:0] mq[$];
  logic [31:0] expq[$];
  bit mov, mun;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    int n;
    n = mq.size();
    chk("count", 32'(bus0.count), n);
    chk("wfull", 32'(bus0.wfull), (n == 16) ? 1 : 0);
    chk("rempty", 32'(bus0.rempty), (n == 0) ? 1 : 0);
    chk("walmost_full", 32'(bus0.walmost_full), (n >= 14) ? 1 : 0);
    chk("ralmost_empty", 32'(bus0.ralmost_empty), (n <= 2) ? 1 : 0);
    chk("overflow", 32'(bus0.overflow), 32'(mov));
    chk("underflow", 32'(bus0.underflow), 32'(mun));
  endtask

  task automatic cyc(bit w, logic [31:0] wd, bit r, bit c);
    bit rd_ok, wr_ok;
    @(negedge clk);
    bus0.winc = w; bus0.wdata = wd; bus0.rinc = r; bus0.clr_err = c;
    rd_ok = r && (mq.size() > 0);
    wr_ok = w && ((mq.size() < 16) || rd_ok);
    if (rd_ok) expq.push_back(mq.pop_front());
    if (wr_ok) mq.push_back(wd);
    if (c) begin
      mov = 1'b0; mun = 1'b0;
    end else begin
      if (w && !wr_ok) mov = 1'b1;
      if (r && !rd_ok) mun = 1'b1;
    end
    @(posedge clk); #1;
    check_flags();
  endtask

  task automatic cyc1(bit w, logic [31:0] wd, bit r);
    @(negedge clk);
    bus1.winc = w; bus1.wdata = wd; bus1.rinc = r; bus1.clr_err = 1'b0;
    @(posedge clk); #1;
  endtask

  // Read monitor: a read accepted at an edge must present the queued head one edge later.
  initial begin
    bit fire;
    forever begin
      @(negedge clk); #2;
      fire = bus0.rinc && !bus0.rempty && !rst0;
      @(posedge clk); #1;
      if (fire && !rst0) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected actual=%0d required=none", bus0.rdata);
        end else begin
          chk("rdata", bus0.rdata, expq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.winc = 0; bus0.rinc = 0; bus0.clr_err = 0; bus0.wdata = '0;
    bus1.winc = 0; bus1.rinc = 0; bus1.clr_err = 0; bus1.wdata = '0;
    mov = 0; mun = 0;
    #12;
    check_flags();
    chk("rst_rdata0", bus0.rdata, 0);
    chk("rst_rempty1", 32'(bus1.rempty), 1);
    chk("rst_rdata1", bus1.rdata, 0);
    @(negedge clk); rst0 = 1'b0; rst1 = 1'b0;

    // fill 100..85, then a rejected 17th write
    for (int i = 0; i < 16; i++) cyc(1, 32'(100 - i), 0, 0);
    cyc(1, 84, 0, 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);

    // simultaneous write/read while full
    for (int i = 0; i < 16; i++) cyc(1, 32'(300 + i), 0, 0);
    cyc(1, 200, 1, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);

    // simultaneous write/read while empty: write wins, underflow sets
    cyc(1, 77, 1, 0);
    cyc(0, 0, 1, 1);

    // interleave across several pointer wraps
    for (int i = 0; i < 40; i++) begin
      cyc(1, 32'(1000 + i), 0, 0);
      cyc(0, 0, 1, 0);
    end

    // mid-operation async reset with a sticky flag pending
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) cyc(1, 32'(500 + i), 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk); #2;
    rst0 = 1'b1;
    #1;
    mq.delete(); expq.delete(); mov = 0; mun = 0;
    check_flags();
    @(negedge clk); rst0 = 1'b0;
    cyc(1, 42, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // FWFT instance
    cyc1(1, 7, 0);
    chk("fwft_rdata_7", bus1.rdata, 7);
    chk("fwft_rempty_0", 32'(bus1.rempty), 0);
    cyc1(0, 0, 1);
    chk("fwft_rempty_1", 32'(bus1.rempty), 1);
    chk("fwft_rdata_0", bus1.rdata, 0);
    cyc1(1, 5, 0);
    chk("fwft_rdata_5", bus1.rdata, 5);
    cyc1(1, 6, 0);
    chk("fwft_head_5", bus1.rdata, 5);
    cyc1(0, 0, 1);
    chk("fwft_rdata_6", bus1.rdata, 6);
    chk("fwft_count_1", 32'(bus1.count), 1);
    cyc1(0, 0, 0);

    cyc(0, 0, 0, 0);
    chk("scoreboard_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Parametrised single-clock FIFO; successor to the team's async FIFO (same data/flag port naming), for same-domain buffering between bench drivers and DUT-side pipelines.
- Adds over the async FIFO:
  - occupancy count
  - programmable almost-full/almost-empty thresholds
  - selectable standard or first-word-fall-through (FWFT) read mode
  - sticky overflow/underflow error flags with clear

Parameters:
- DSIZE, 32, data width in bits
- ASIZE, 4, address width; depth = 2^ASIZE entries
- AFULL_TH, 14, walmost_full asserts when count >= AFULL_TH (1..2^ASIZE)
- AEMPTY_TH, 2, ralmost_empty asserts when count <= AEMPTY_TH (0..2^ASIZE-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wdata  in  DSIZE  write data
- winc  in  1  write request
- rinc  in  1  read request (standard: request; FWFT: pop/acknowledge head)
- clr_err  in  1  synchronous clear of overflow/underflow
- rdata  out  DSIZE  read data
- wfull  out  1  count == 2^ASIZE
- rempty  out  1  count == 0
- walmost_full  out  1  count >= AFULL_TH
- ralmost_empty  out  1  count <= AEMPTY_TH
- count  out  ASIZE+1  current occupancy, 0..2^ASIZE
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected

Behaviour:
- Reset (async assert, released synchronously to clk):
  - wptr = rptr = count = 0
  - rempty = 1, wfull = 0, walmost_full = 0 (unless AFULL_TH = 0, which is illegal), ralmost_empty = 1
  - overflow = underflow = 0, rdata = 0
  - Memory contents are not reset.
- Reset mid-operation: all state returns to reset values immediately. Queued data is discarded.
- Accept rules, per rising edge:
  - wr_ok = winc & (~wfull | rinc_ok)
  - rd_ok = rinc & ~rempty
  - rinc_ok = rd_ok
- Write on wr_ok: mem[wptr] <= wdata; wptr increments modulo 2^ASIZE.
- Read on rd_ok: rptr increments modulo 2^ASIZE.
- count next value:
  - count + 1 if wr_ok & ~rd_ok
  - count - 1 if rd_ok & ~wr_ok
  - otherwise unchanged
- Simultaneous write and read:
  - When full: both accepted; count stays 2^ASIZE; no overflow.
  - When empty: write accepted, read rejected; underflow sets; count becomes 1.
- Flags:
  - All flags are combinational decodes of the registered count, so they update in the same cycle count changes.
  - Pointer wrap-around has no effect on flags.
- overflow: set on winc & ~wr_ok. underflow: set on rinc & ~rd_ok.
  - Both hold until clr_err = 1 at a clock edge.
  - clr_err takes priority over a same-cycle set.
- Standard mode (FWFT = 0):
  - rdata <= mem[rptr] on rd_ok. Data is valid on the edge after the rinc edge (1-cycle latency).
  - rdata holds its last value otherwise.
- FWFT mode (FWFT = 1):
  - rdata = mem[rptr] (combinational from the register array) whenever rempty = 0, so the head is visible with 0 latency.
  - rd_ok pops the head.
  - When rempty = 1, rdata is driven to 0.
  - Write-to-visible latency: a write at edge N makes rempty = 0 and rdata valid immediately after edge N.
- Data ordering is strictly first-in first-out across pointer wrap.
- Storage is a register array of 2^ASIZE x DSIZE. No read-during-write bypass is needed, because reads only occur when count >= 1.

Test Plan:
- Configuration: DSIZE=32, ASIZE=4, AFULL_TH=14, AEMPTY_TH=2, FWFT=0.
- Fill and drain:
  - Write 16 words 100 down to 85 -> count 16; wfull = 1 after the 16th edge; walmost_full = 1 from count 14.
  - Read 16 words -> rdata 100..85 in order, each one edge after its rinc; rempty = 1 after the last.
- Overflow/underflow:
  - A 17th write with wdata=84 while full -> overflow = 1, count stays 16, and 84 is never read.
  - rinc while empty -> underflow = 1.
  - clr_err pulse -> both flags return to 0.
- Simultaneous full: at count 16, winc + rinc in one cycle with wdata=200 -> count stays 16, rdata = head value, no overflow; 200 is read last.
- Interleave/wrap: repeat (write 1, read 1) 40 times (pointers wrap more than twice) -> count toggles 0/1, rempty toggles, data order preserved, no error flags.
- FWFT=1 run:
  - Write 7 -> rdata = 7 immediately after the write edge, rempty = 0.
  - rinc -> rempty = 1, rdata = 0.
  - Write 5 then 6, then pop -> rdata shows 6 after the pop edge.
- Mid-operation reset: at count 9, assert rst asynchronously (between edges) -> count = 0, rempty = 1, flags cleared immediately.
  - After release, the first write of 42 then a read returns 42.
